// File: rtl/mdu_seq_ctrl.sv
// Issue/latency sequencer for the E-stage multiply/divide unit: start and HI/LO
// write strobes, completion commit, D-stage stall and collision reporting.
module mdu_seq_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10,
    parameter int unsigned CW         = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       int_req_i,
    input  logic       op_valid_i,
    input  logic [3:0] op_i,
    input  logic       d_is_mdu_i,
    output logic       start_o,
    output logic [3:0] start_op_o,
    output logic       hi_we_o,
    output logic       lo_we_o,
    output logic       commit_o,
    output logic       busy_o,
    output logic       stall_o,
    output logic       collide_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      cur_op_q, cur_op_d;

    logic long_op, div_op, issue;

    always_comb begin
        long_op = 1'b0;
        div_op  = 1'b0;
        unique case (op_i)
            4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12: long_op = 1'b1;
            4'd3, 4'd4: begin
                long_op = 1'b1;
                div_op  = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are gated by reset so they drop the moment reset rises.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_op_d   = cur_op_q;
        start_o    = 1'b0;
        start_op_o = 4'd0;
        hi_we_o    = 1'b0;
        lo_we_o    = 1'b0;
        commit_o   = 1'b0;
        busy_o     = 1'b0;
        collide_o  = 1'b0;
        issue      = 1'b0;

        unique case (state_q)
            StIdle: begin
                issue = op_valid_i && !int_req_i && !rst_i;
                if (issue) begin
                    hi_we_o = (op_i == 4'd7);
                    lo_we_o = (op_i == 4'd8);
                    if (long_op) begin
                        start_o    = 1'b1;
                        start_op_o = op_i;
                        state_d    = StRun;
                        cnt_d      = div_op ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        cur_op_d   = op_i;
                    end
                end
            end
            StRun: begin
                busy_o    = !rst_i;
                collide_o = op_valid_i && !rst_i;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    commit_o = !rst_i;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        stall_o = d_is_mdu_i && (busy_o || start_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            cur_op_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_op_q <= cur_op_d;
        end
    end

    a_run_sane: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StRun) |-> (cur_op_q != 4'd0 && cnt_q != '0));

endmodule
